// File: rtl/icache_2way_pkg.sv
// Shared definitions for the 2-way instruction cache: datapath width,
// FSM state encodings and the replacement-victim selection rule.
package icache_2way_pkg;

    localparam int XLEN = 32;

    typedef enum logic [0:0] {
        ICACHE_IDLE   = 1'b0,
        ICACHE_REFILL = 1'b1
    } icache_state_e;

    // Fill an empty way first (way 0 before way 1), otherwise evict the LRU way.
    function automatic logic pick_victim(input logic valid0, input logic valid1, input logic lru);
        logic victim;
        if (!valid0) begin
            victim = 1'b0;
        end else if (!valid1) begin
            victim = 1'b1;
        end else begin
            victim = lru;
        end
        return victim;
    endfunction

endpackage

// File: rtl/icache_2way_if.sv
// Word-serial refill port between the instruction cache and instruction memory.
interface icache_2way_if;
    import icache_2way_pkg::*;

    logic            mem_read;
    logic [XLEN-1:0] mem_addr;
    logic            mem_ready;
    logic [XLEN-1:0] mem_data;

    modport master (
        output mem_read,
        output mem_addr,
        input  mem_ready,
        input  mem_data
    );

    modport slave (
        input  mem_read,
        input  mem_addr,
        output mem_ready,
        output mem_data
    );

endinterface

// File: rtl/icache_2way_way.sv
// One way of the instruction cache: per-set valid bit, tag and line data,
// plus the tag compare for the set selected by the fetch address.
module icache_way
    import icache_2way_pkg::*;
#(
    parameter  int SETS       = 32,
    parameter  int LINE_WORDS = 4,
    parameter  int TAG_W      = 23,
    localparam int INDEX_W    = $clog2(SETS),
    localparam int OFF_W      = $clog2(LINE_WORDS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_index,
    input  logic [OFF_W-1:0]   rd_offset,
    input  logic [TAG_W-1:0]   rd_tag,
    output logic               valid,
    output logic               match,
    output logic [XLEN-1:0]    rd_data,
    input  logic               wr_data_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [OFF_W-1:0]   wr_offset,
    input  logic [XLEN-1:0]    wr_data,
    input  logic               set_valid,
    input  logic [TAG_W-1:0]   set_tag,
    input  logic               clear_all
);

    logic [SETS-1:0]  valid_r;
    logic [TAG_W-1:0] tag_r  [SETS];
    logic [XLEN-1:0]  data_r [SETS*LINE_WORDS];

    // Valid bits: cleared by reset or flush, set when a refill completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= '0;
        end else if (clear_all) begin
            valid_r <= '0;
        end else if (set_valid) begin
            valid_r[wr_index] <= 1'b1;
        end
    end

    // Tag array: written together with the valid bit at the end of a refill.
    always_ff @(posedge clk) begin
        if (set_valid) begin
            tag_r[wr_index] <= set_tag;
        end
    end

    // Data array: one refill word per accepted memory beat; never reset.
    always_ff @(posedge clk) begin
        if (wr_data_en) begin
            data_r[{wr_index, wr_offset}] <= wr_data;
        end
    end

    assign valid   = valid_r[rd_index];
    assign match   = valid && (tag_r[rd_index] == rd_tag);
    assign rd_data = data_r[{rd_index, rd_offset}];

endmodule

// File: rtl/icache_2way.sv
// 2-way set-associative instruction cache with per-set LRU replacement,
// latched-address word-serial refill and a whole-cache flush for fence.i.
module icache_2way
    import icache_2way_pkg::*;
#(
    parameter int SETS       = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    input  logic            fetch_en,
    input  logic            flush,
    output logic            hit,
    output logic            miss,
    output logic            ready,
    output logic            busy,
    output logic [XLEN-1:0] instruction,
    icache_2way_if.master   mem
);

    localparam int INDEX_W = $clog2(SETS);
    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int TAG_W   = XLEN - INDEX_W - OFF_W - 2;
    localparam int LINE_W  = XLEN - OFF_W - 2;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    icache_state_e state_r;
    icache_state_e state_next;

    logic              mem_read_r;
    logic [XLEN-1:0]   mem_addr_r;
    logic [OFF_W-1:0]  count_r;
    logic [LINE_W-1:0] miss_line_r;
    logic              victim_r;
    logic              flush_pending_r;
    logic [SETS-1:0]   lru_r;

    logic [OFF_W-1:0]   pc_offset_s;
    logic [INDEX_W-1:0] pc_index_s;
    logic [TAG_W-1:0]   pc_tag_s;
    logic [INDEX_W-1:0] miss_index_s;
    logic [TAG_W-1:0]   miss_tag_s;

    logic            valid0_s, valid1_s;
    logic            match0_s, match1_s;
    logic [XLEN-1:0] rdata0_s, rdata1_s;

    logic            hit_s, miss_s;
    logic [XLEN-1:0] instr_s;
    logic            final_beat_s;
    logic            flush_any_s;
    logic            set_valid_s;
    logic            clear_all_s;
    logic            wr0_s, wr1_s;
    logic            unused_s;

    assign pc_offset_s  = pc[OFF_W+1:2];
    assign pc_index_s   = pc[OFF_W+2 +: INDEX_W];
    assign pc_tag_s     = pc[XLEN-1 -: TAG_W];
    assign miss_index_s = miss_line_r[INDEX_W-1:0];
    assign miss_tag_s   = miss_line_r[LINE_W-1:INDEX_W];
    assign unused_s     = ^pc[1:0];

    // A flush seen on the final beat is treated exactly like an earlier deferred one.
    assign final_beat_s = (state_r == ICACHE_REFILL) && mem.mem_ready && (count_r == LAST_BEAT);
    assign flush_any_s  = flush || flush_pending_r;
    assign set_valid_s  = final_beat_s && !flush_any_s;
    assign clear_all_s  = ((state_r == ICACHE_IDLE) && flush) || (final_beat_s && flush_any_s);
    assign wr0_s        = (state_r == ICACHE_REFILL) && mem.mem_ready && (victim_r == 1'b0);
    assign wr1_s        = (state_r == ICACHE_REFILL) && mem.mem_ready && (victim_r == 1'b1);

    icache_way #(.SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W)) u_way0 (
        .clk        (clk),
        .reset      (reset),
        .rd_index   (pc_index_s),
        .rd_offset  (pc_offset_s),
        .rd_tag     (pc_tag_s),
        .valid      (valid0_s),
        .match      (match0_s),
        .rd_data    (rdata0_s),
        .wr_data_en (wr0_s),
        .wr_index   (miss_index_s),
        .wr_offset  (count_r),
        .wr_data    (mem.mem_data),
        .set_valid  (set_valid_s && (victim_r == 1'b0)),
        .set_tag    (miss_tag_s),
        .clear_all  (clear_all_s)
    );

    icache_way #(.SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W)) u_way1 (
        .clk        (clk),
        .reset      (reset),
        .rd_index   (pc_index_s),
        .rd_offset  (pc_offset_s),
        .rd_tag     (pc_tag_s),
        .valid      (valid1_s),
        .match      (match1_s),
        .rd_data    (rdata1_s),
        .wr_data_en (wr1_s),
        .wr_index   (miss_index_s),
        .wr_offset  (count_r),
        .wr_data    (mem.mem_data),
        .set_valid  (set_valid_s && (victim_r == 1'b1)),
        .set_tag    (miss_tag_s),
        .clear_all  (clear_all_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ICACHE_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Lookup outputs and next state; lookups only happen in IDLE.
    always_comb begin
        state_next = state_r;
        hit_s      = 1'b0;
        miss_s     = 1'b0;
        instr_s    = '0;
        case (state_r)
            ICACHE_IDLE: begin
                hit_s  = fetch_en && (match0_s || match1_s) && !flush;
                miss_s = fetch_en && !(match0_s || match1_s) && !flush;
                if (hit_s) begin
                    instr_s = match0_s ? rdata0_s : rdata1_s;
                end else begin
                    instr_s = '0;
                end
                if (miss_s) begin
                    state_next = ICACHE_REFILL;
                end else begin
                    state_next = ICACHE_IDLE;
                end
            end
            ICACHE_REFILL: begin
                if (final_beat_s) begin
                    state_next = ICACHE_IDLE;
                end else begin
                    state_next = ICACHE_REFILL;
                end
            end
            default: begin
                state_next = ICACHE_IDLE;
            end
        endcase
    end

    // Refill bookkeeping: everything the refill uses is latched on the miss edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_read_r      <= 1'b0;
            mem_addr_r      <= '0;
            count_r         <= '0;
            miss_line_r     <= '0;
            victim_r        <= 1'b0;
            flush_pending_r <= 1'b0;
        end else begin
            case (state_r)
                ICACHE_IDLE: begin
                    if (miss_s) begin
                        miss_line_r <= pc[XLEN-1:OFF_W+2];
                        victim_r    <= pick_victim(valid0_s, valid1_s, lru_r[pc_index_s]);
                        mem_read_r  <= 1'b1;
                        mem_addr_r  <= {pc[XLEN-1:OFF_W+2], {(OFF_W+2){1'b0}}};
                        count_r     <= '0;
                    end
                end
                ICACHE_REFILL: begin
                    if (flush) begin
                        flush_pending_r <= 1'b1;
                    end
                    if (mem.mem_ready) begin
                        if (count_r == LAST_BEAT) begin
                            mem_read_r      <= 1'b0;
                            flush_pending_r <= 1'b0;
                        end else begin
                            count_r    <= count_r + OFF_W'(1);
                            mem_addr_r <= mem_addr_r + XLEN'(4);
                        end
                    end
                end
                default: begin
                    mem_read_r <= 1'b0;
                end
            endcase
        end
    end

    // LRU bits: point at the way not just used, by a hit or by a completed refill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lru_r <= '0;
        end else if (clear_all_s) begin
            lru_r <= '0;
        end else if (hit_s) begin
            lru_r[pc_index_s] <= match0_s;
        end else if (set_valid_s) begin
            lru_r[miss_index_s] <= ~victim_r;
        end
    end

    assign hit          = hit_s;
    assign miss         = miss_s;
    assign ready        = hit_s;
    assign instruction  = instr_s;
    assign busy         = (state_r == ICACHE_REFILL);
    assign mem.mem_read = mem_read_r;
    assign mem.mem_addr = mem_addr_r;

endmodule

// File: tb/tb_icache_2way.sv
// Scoreboard bench for icache_2way: expected refill addresses and fetched
// words are queued when a fetch is driven and consumed as the DUT responds.
module tb_icache_2way;
    import icache_2way_pkg::*;

    localparam int SETS       = 32;
    localparam int LINE_WORDS = 4;
    localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);

    logic            clk = 1'b0;
    logic            reset;
    logic [XLEN-1:0] pc;
    logic            fetch_en;
    logic            flush;
    logic            hit, miss, ready, busy;
    logic [XLEN-1:0] instruction;

    icache_2way_if mem_bus ();

    icache_2way #(.SETS(SETS), .LINE_WORDS(LINE_WORDS)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .fetch_en    (fetch_en),
        .flush       (flush),
        .hit         (hit),
        .miss        (miss),
        .ready       (ready),
        .busy        (busy),
        .instruction (instruction),
        .mem         (mem_bus)
    );

    always #5 clk = ~clk;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_word_q[$];
    bit          toggle_mode  = 1'b0;

    // Instruction memory contents: a scrambled function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign mem_bus.mem_data = mem_word(mem_bus.mem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Mid-cycle sample point; also scores every accepted refill beat.
    task automatic to_sample();
        @(negedge clk);
        if (busy) begin
            check("refill_quiet", {29'd0, hit, miss, ready}, 32'd0);
            check("refill_mem_read", 32'(mem_bus.mem_read), 32'd1);
        end
        if (mem_bus.mem_read && mem_bus.mem_ready) begin
            if (exp_addr_q.size() == 0) begin
                check("unexpected_beat", 32'(exp_addr_q.size()), 32'd1);
            end else begin
                check("mem_addr", mem_bus.mem_addr, exp_addr_q.pop_front());
            end
        end
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
        if (toggle_mode) mem_bus.mem_ready = ~mem_bus.mem_ready;
    endtask

    task automatic wait_refill(input logic [31:0] alt_pc, input int flush_at, input int rst_at);
        int cycles;
        cycles = 0;
        while (busy && cycles < 64) begin
            if (alt_pc != 32'd0 && cycles == 1) pc = alt_pc;
            flush = (cycles == flush_at);
            if (cycles == rst_at) begin
                reset = 1'b1;
                #1;
                check("rst_mem_read", 32'(mem_bus.mem_read), 32'd0);
                check("rst_mem_addr", mem_bus.mem_addr, 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                exp_addr_q.delete();
                flush    = 1'b0;
                fetch_en = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                to_drive();
                return;
            end
            to_sample();
            to_drive();
            cycles++;
        end
        flush = 1'b0;
        check("refill_done", 32'(busy), 32'd0);
        check("beats_left", 32'(exp_addr_q.size()), 32'd0);
        check("mem_read_drop", 32'(mem_bus.mem_read), 32'd0);
        if (!toggle_mode) check("miss_penalty", 32'(cycles), 32'(LINE_WORDS));
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr, input bit exp_hit,
                         input logic [31:0] alt_pc, input int flush_at, input int rst_at);
        pc       = addr;
        fetch_en = 1'b1;
        if (exp_hit) begin
            exp_word_q.push_back(mem_word(addr));
        end else begin
            for (int i = 0; i < LINE_WORDS; i++) exp_addr_q.push_back((addr & ~LINE_MASK) + 32'(4 * i));
        end
        to_sample();
        check({tag, "_hit"}, 32'(hit), 32'(exp_hit));
        check({tag, "_miss"}, 32'(miss), 32'(!exp_hit));
        check({tag, "_ready"}, 32'(ready), 32'(exp_hit));
        if (exp_hit) check({tag, "_instr"}, instruction, exp_word_q.pop_front());
        else         check({tag, "_instr0"}, instruction, 32'd0);
        to_drive();
        if (!exp_hit) wait_refill(alt_pc, flush_at, rst_at);
    endtask

    initial begin
        reset             = 1'b1;
        pc                = 32'd0;
        fetch_en          = 1'b0;
        flush             = 1'b0;
        mem_bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state_read", 32'(mem_bus.mem_read), 32'd0);
        check("rst_state_addr", mem_bus.mem_addr, 32'd0);
        check("rst_state_out", {28'd0, hit, miss, ready, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        to_drive();

        // Cold fill, same-set pair, LRU-driven evictions (all lines in set 0).
        fetch("cold",    32'h0000_1000, 1'b0, 32'd0, -1, -1);
        fetch("w0",      32'h0000_1000, 1'b1, 32'd0, -1, -1);
        fetch("w3",      32'h0000_100C, 1'b1, 32'd0, -1, -1);
        fetch("b_miss",  32'h0000_2000, 1'b0, 32'd0, -1, -1);
        fetch("b_hit",   32'h0000_2004, 1'b1, 32'd0, -1, -1);
        fetch("a_hit",   32'h0000_1008, 1'b1, 32'd0, -1, -1);
        fetch("c_miss",  32'h0000_3000, 1'b0, 32'd0, -1, -1);
        fetch("a_keep",  32'h0000_1000, 1'b1, 32'd0, -1, -1);
        fetch("b_gone",  32'h0000_2000, 1'b0, 32'd0, -1, -1);
        fetch("b_back",  32'h0000_2008, 1'b1, 32'd0, -1, -1);
        fetch("c_gone",  32'h0000_3004, 1'b0, 32'd0, -1, -1);
        fetch("a_gone",  32'h0000_1004, 1'b0, 32'd0, -1, -1);
        fetch("c_keep",  32'h0000_3000, 1'b1, 32'd0, -1, -1);
        fetch("a_back",  32'h0000_100C, 1'b1, 32'd0, -1, -1);

        // Stalling memory with pc moved to a resident line during the refill.
        toggle_mode = 1'b1;
        fetch("tog",     32'h0000_4014, 1'b0, 32'h0000_1000, -1, -1);
        toggle_mode       = 1'b0;
        mem_bus.mem_ready = 1'b1;
        fetch("tog_w1",  32'h0000_4014, 1'b1, 32'd0, -1, -1);
        fetch("tog_w3",  32'h0000_401C, 1'b1, 32'd0, -1, -1);

        // Flush while idle: no lookup in that cycle, everything invalid after.
        pc       = 32'h0000_1000;
        fetch_en = 1'b1;
        flush    = 1'b1;
        to_sample();
        check("flush_idle_out", {29'd0, hit, miss, ready}, 32'd0);
        to_drive();
        flush = 1'b0;
        fetch("fl_a",    32'h0000_1000, 1'b0, 32'd0, -1, -1);
        fetch("fl_e",    32'h0000_4010, 1'b0, 32'd0, -1, -1);
        fetch("fl_a_h",  32'h0000_1000, 1'b1, 32'd0, -1, -1);

        // Flush deferred from mid-refill and from the final beat.
        fetch("fmid",    32'h0000_2000, 1'b0, 32'd0, 1, -1);
        fetch("fmid_re", 32'h0000_2000, 1'b0, 32'd0, -1, -1);
        fetch("fmid_a",  32'h0000_1000, 1'b0, 32'd0, -1, -1);
        fetch("ffin",    32'h0000_3000, 1'b0, 32'd0, LINE_WORDS - 1, -1);
        fetch("ffin_re", 32'h0000_3000, 1'b0, 32'd0, -1, -1);
        fetch("ffin_b",  32'h0000_2000, 1'b0, 32'd0, -1, -1);

        // Reset on the second refill beat leaves no partial line behind.
        fetch("rmid",    32'h0000_1000, 1'b0, 32'd0, -1, 1);
        fetch("rmid_re", 32'h0000_1000, 1'b0, 32'd0, -1, -1);
        fetch("rmid_c",  32'h0000_3000, 1'b0, 32'd0, -1, -1);
        fetch("rmid_h",  32'h0000_1004, 1'b1, 32'd0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/icache_2way.md
Name: icache_2way

Overview:
- Parametrised 2-way set-associative instruction cache; successor to the direct-mapped instruction cache in the fetch stage.
- Sits between the IF-stage PC and the instruction memory port.
- Adds configurable sets and line length, per-set LRU replacement, a latched miss address (refill is immune to PC changes), and a whole-cache flush for fence.i.
- Uses the same word-serial mem_read/mem_ready refill handshake as the current cache.

Parameters:
- SETS, 32, number of sets; power of two, at least 2.
- LINE_WORDS, 4, 32-bit words per line; power of two, at least 2.

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- pc  input  XLEN  fetch address; word aligned
- fetch_en  input  1  fetch request this cycle
- flush  input  1  invalidate all lines (fence.i)
- hit  output  1  lookup hit
- miss  output  1  lookup miss; a refill starts next cycle
- ready  output  1  instruction valid this cycle
- busy  output  1  refill or deferred flush in progress
- instruction  output  XLEN  fetched word
- mem_read  output  1  refill request, held for the whole refill
- mem_addr  output  XLEN  current refill word address
- mem_ready  input  1  mem_data valid; one word accepted per cycle
- mem_data  input  XLEN  refill word

Behaviour:
- Address split:
  - offset = pc[log2(LINE_WORDS)+1:2]
  - index = next log2(SETS) bits
  - tag = remaining upper bits; TAG_W = XLEN - log2(SETS) - log2(LINE_WORDS) - 2
- Per set, per way: valid, tag, LINE_WORDS data words. One LRU bit per set; LRU=w means way w is least recently used.
- States: IDLE, REFILL.
- Lookup (combinational, IDLE only):
  - match_w = valid[w][index] && tag[w][index]==tag(pc)
  - hit = fetch_en && (match_0 || match_1) && !flush
  - miss = fetch_en && !(match_0 || match_1) && !flush
  - ready = hit
  - instruction = word from the matching way; 0 when there is no hit
  - In REFILL: hit, miss and ready are all 0.
- Hit latency: 0 cycles (same-cycle data). On a hit, the set's LRU bit is set to the other way at the clock edge.
- Miss, IDLE to REFILL at the clock edge:
  - Latch miss_line = pc[XLEN-1:log2(LINE_WORDS)+2] and miss_index.
  - Victim: way 0 if invalid, else way 1 if invalid, else the LRU way.
  - mem_read<=1; mem_addr<={miss_line, 0 offset}; beat count <= 0.
- REFILL:
  - mem_read stays 1.
  - On each mem_ready: write mem_data into victim[miss_index][count].
  - Non-final beat: count+1, mem_addr+4.
  - Final beat (count==LINE_WORDS-1): set victim valid and tag; set LRU to the other way; mem_read<=0; go to IDLE.
  - Without mem_ready, state and outputs hold indefinitely.
- Refill uses only latched values. Changes to pc or fetch_en during REFILL have no effect on the refill.
- Miss penalty with mem_ready stuck high: 1 + LINE_WORDS cycles. The re-presented pc hits on the first IDLE cycle.
- Victim lines are not written back (read-only cache).
- Flush:
  - In IDLE: all valid and LRU bits clear at the edge. hit and miss are forced 0 in the flush cycle.
  - During REFILL: set flush_pending and let the refill finish, but the refilled line is NOT marked valid. All valid and LRU bits clear on the final-beat edge, and flush_pending clears.
  - flush on the final-beat cycle itself behaves the same as a deferred flush.
- busy = (state==REFILL).
- Reset (also mid-refill): state IDLE, mem_read 0, mem_addr 0, count 0, flush_pending 0, all valid and LRU bits 0. Data arrays are not reset. Combinational outputs are 0 because no line is valid.
- Data arrays are written only from mem_data, so no read-after-write hazard exists in IDLE.

Decomposition:
- Shared package (isa.v): XLEN, and ICACHE_IDLE / ICACHE_REFILL state encodings.
- Derived widths (INDEX_W, OFF_W, TAG_W) are localparams via $clog2.
- One natural sub-module: icache_way (valid/tag/data storage plus match compare for one way), instantiated twice. The top holds the FSM, LRU bits and output mux.

Test Plan:
- Cold miss at pc=0x0000_1000, mem_ready always 1:
  - miss=1 in cycle 0.
  - mem_addr steps 0x1000, 0x1004, 0x1008, 0x100C.
  - Next IDLE cycle: hit=1 and instruction = word 0 supplied.
  - pc=0x100C then hits with word 3.
- Two lines in the same set (0x1000, 0x2000 with SETS=32): both fill and both hit after refill. Each hit flips LRU; verify by checking the victim on the next miss.
- Third conflicting line 0x3000 after hitting 0x1000 last: the 0x2000 way is evicted. 0x1000 still hits; 0x2000 misses.
- mem_ready toggled 1/0 with pc changed mid-refill:
  - Refill completes at the original latched line address.
  - hit, miss and ready stay 0 throughout REFILL.
- Flush in IDLE after a fill: the next fetch of 0x1000 misses. Flush asserted mid-refill: refill completes, mem_read drops, and the same pc misses again.
- reset asserted on the second beat of a refill: mem_read=0 and mem_addr=0 immediately. After release, pc=0x1000 misses (no partial line is valid).
